// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake; optional iterative multiplier enabled by ALU_MC_MUL_EN
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake with op[2:0], a, b;
//        out_valid/out_ready result handshake with result and flags cout, ovf, zero, neg, err.
// Without ALU_MC_MUL_EN, op 110 behaves exactly like the illegal op 111.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);
`ifdef ALU_MC_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif
  state_t state;
  logic [WIDTH:0] sum, diff;
  logic signed [WIDTH-1:0] sra;
  logic [WIDTH-1:0] asr, res;
  logic c, v, e;
`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod, nxt;
  logic [WIDTH:0] madd;
  logic [CW-1:0] cnt;
`endif
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    // kept in its own signed variable so the shift stays arithmetic
    sra  = $signed(a) >>> b[SW-1:0];
    asr  = (b >= WIDTH'(WIDTH)) ? {WIDTH{a[WIDTH-1]}} : sra;
    res  = op == 3'b000 ? ~a :
           op == 3'b001 ? a & b :
           op == 3'b010 ? asr :
           op == 3'b011 ? a ^ b :
           op == 3'b100 ? sum[WIDTH-1:0] :
           op == 3'b101 ? diff[WIDTH-1:0] : '0;
    c    = op == 3'b100 ? sum[WIDTH] : op == 3'b101 ? diff[WIDTH] : 1'b0;
    v    = op == 3'b100 ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
           op == 3'b101 ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    // 110 only reaches this path when the multiplier is absent
    e    = op[2] & op[1];
  end
`ifdef ALU_MC_MUL_EN
  // shift-add step: upper half accumulates, lower half shifts out the multiplier bits
  always_comb begin
    madd = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    nxt  = {madd, prod[WIDTH-1:1]};
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_MC_MUL_EN
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else if (state == IDLE && in_valid && op == 3'b110) begin
      state    <= BUSY;
      in_ready <= 1'b0;
      mcand    <= a;
      prod     <= {{WIDTH{1'b0}}, b};
      cnt      <= '0;
    end else if (state == BUSY) begin
      prod <= nxt;
      cnt  <= cnt + 1'b1;
      // the last step's product is registered directly so DONE follows exactly WIDTH busy cycles
      if (cnt == CW'(WIDTH - 1)) begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= nxt[WIDTH-1:0];
        cout      <= |nxt[2*WIDTH-1:WIDTH];
        ovf       <= 1'b0;
        zero      <= nxt[WIDTH-1:0] == '0;
        neg       <= nxt[WIDTH-1];
        err       <= 1'b0;
      end
`endif
    end else if (state == IDLE && in_valid) begin
      state     <= DONE;
      in_ready  <= 1'b0;
      out_valid <= 1'b1;
      result    <= res;
      cout      <= c;
      ovf       <= v;
      zero      <= res == '0;
      neg       <= res[WIDTH-1];
      err       <= e;
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32
module tb_alu_mc;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, cout, ovf, zero, neg, err;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0, result;
  logic seen;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .err(err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  // flags order: {cout, ovf, zero, neg, err}
  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [4:0] f);
    chk({tag, " valid"}, 64'(out_valid), 64'(1));
    chk({tag, " result"}, 64'(result), 64'(r));
    chk({tag, " flags"}, 64'({cout, ovf, zero, neg, err}), 64'(f));
  endtask
  initial begin
    tick();
    tick();
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    chk("reset flags", 64'({cout, ovf, zero, neg, err}), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("release in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    issue(3'b100, 32'hFFFF_FFFF, 32'h1);
    expect_out("add carry", 32'h0, 5'b10100);
    chk("add in_ready low", 64'(in_ready), 64'(0));
    tick();
    chk("back to idle", 64'({in_ready, out_valid}), 64'(2'b10));
    issue(3'b100, 32'h7FFF_FFFF, 32'h1);
    expect_out("add ovf", 32'h8000_0000, 5'b01010);
    tick();
    issue(3'b101, 32'h8000_0000, 32'h1);
    expect_out("sub ovf", 32'h7FFF_FFFF, 5'b01000);
    tick();
    issue(3'b101, 32'h3, 32'h5);
    expect_out("sub borrow", 32'hFFFF_FFFE, 5'b10010);
    tick();
    issue(3'b010, 32'h8000_0000, 32'd4);
    expect_out("asr 4", 32'hF800_0000, 5'b00010);
    tick();
    issue(3'b010, 32'h8000_0000, 32'd40);
    expect_out("asr 40", 32'hFFFF_FFFF, 5'b00010);
    tick();
    issue(3'b010, 32'h4000_0000, 32'd2);
    expect_out("asr pos", 32'h1000_0000, 5'b00000);
    tick();
    issue(3'b010, 32'h7000_0000, 32'd32);
    expect_out("asr 32 pos", 32'h0, 5'b00100);
    tick();
    issue(3'b000, 32'h0, 32'h1234);
    expect_out("not", 32'hFFFF_FFFF, 5'b00010);
    tick();
    issue(3'b001, 32'h0000_F0F0, 32'h0000_FF00);
    expect_out("and", 32'h0000_F000, 5'b00000);
    tick();
    issue(3'b111, 32'h5, 32'h7);
    expect_out("illegal", 32'h0, 5'b00101);
    tick();
`ifdef ALU_MC_MUL_EN
    issue(3'b110, 32'h0001_0000, 32'h0001_0001);
    seen = 1'b0;
    repeat (31) begin
      seen |= out_valid | in_ready;
      tick();
    end
    chk("mul busy quiet", 64'(seen | out_valid | in_ready), 64'(0));
    tick();
    expect_out("mul", 32'h0001_0000, 5'b10000);
    tick();
    issue(3'b110, 32'd7, 32'd6);
    repeat (32) tick();
    expect_out("mul small", 32'd42, 5'b00000);
    tick();
`else
    issue(3'b110, 32'h0001_0000, 32'h0001_0001);
    expect_out("mul disabled", 32'h0, 5'b00101);
    tick();
`endif
    out_ready = 1'b0;
    issue(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    expect_out("xor", 32'h0FF0_0FF0, 5'b00000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op = 3'b100;
      a = 32'(i + 1);
      b = 32'h1111;
      in_valid = 1'b1;
      tick();
      seen |= (result != 32'h0FF0_0FF0) | ~out_valid | in_ready;
    end
    chk("backpressure hold", 64'(seen), 64'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("after drain", 64'({in_ready, out_valid}), 64'(2'b10));
    chk("xor held after drain", 64'(result), 64'(32'h0FF0_0FF0));
`ifdef ALU_MC_MUL_EN
    issue(3'b110, 32'd3, 32'd5);
`else
    out_ready = 1'b0;
    issue(3'b100, 32'd3, 32'd4);
`endif
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 64'(out_valid), 64'(0));
    chk("async reset result", 64'(result), 64'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= out_valid;
    end
    chk("no stale output", 64'(seen), 64'(0));
    issue(3'b100, 32'd2, 32'd2);
    expect_out("add after reset", 32'd4, 5'b00000);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal range 8..64.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  operation select, encoding per REQ-012.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 out_valid  output  1  result/flags valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  operation result.
REQ-011 cout, ovf, zero, neg, err  output  1 each  carry/borrow, signed overflow, result==0, result MSB, illegal op.

Function
REQ-012 op encoding: 000 NOT A; 001 A AND B; 010 arithmetic shift right A by B; 011 A XOR B; 100 A+B; 101 A-B; 110 MUL (low WIDTH bits of unsigned A*B); 111 illegal.
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; request accepted on cycle where in_valid && in_ready; op, A, B captured at acceptance.
REQ-015 Single-cycle ops (000-101, 111): IDLE -> DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-016 MUL: IDLE -> BUSY; iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in BUSY, then DONE; out_valid asserts WIDTH+1 cycles after acceptance.
REQ-017 DONE: result and flags held stable while out_valid=1 and out_ready=0; out_valid && out_ready -> IDLE next cycle.
REQ-018 No request accepted in BUSY or DONE; in_valid there is ignored; input changes there do not affect result.
REQ-019 ASR: shift amount is B treated as unsigned; amount >= WIDTH yields all bits equal to A[WIDTH-1].
REQ-020 ADD: cout = carry out of bit WIDTH-1; ovf = signed overflow.
REQ-021 SUB: cout = 1 when A < B unsigned (borrow); ovf = signed overflow of A-B.
REQ-022 MUL: cout = 1 when upper WIDTH bits of full product nonzero; ovf = 0.
REQ-023 Logic ops and shift: cout = 0, ovf = 0.
REQ-024 zero and neg derived from final result for every op, including err case.
REQ-025 op 111: result = 0, err = 1, zero = 1, other flags 0; err = 0 for all legal ops.

Reset
REQ-026 Reset_n low SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, result=0, all flags 0, multiplier accumulator/counter cleared.
REQ-027 Reset asserted mid-MUL or in DONE discards the operation; no out_valid produced for it after release.
REQ-028 First acceptance possible on the first rising edge after Reset_n deasserts.

Configuration
REQ-029 Macro ALU_MC_MUL_EN: when defined, op 110 performs MUL per REQ-016/REQ-022 and BUSY state exists.
REQ-030 Without ALU_MC_MUL_EN: no multiplier hardware or BUSY state; op 110 treated exactly as illegal op 111 (latency 1, err=1, result=0).

Verification (WIDTH=32)
REQ-031 ADD A=0xFFFFFFFF, B=1 -> 1 cycle later out_valid=1, result=0, cout=1, zero=1, ovf=0.
REQ-032 SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, ovf=1, cout=0, neg=0; SUB A=3, B=5 -> result=0xFFFFFFFE, cout=1, neg=1.
REQ-033 ASR A=0x80000000, B=4 -> 0xF8000000; B=40 -> 0xFFFFFFFF.
REQ-034 MUL (macro defined) A=0x10000, B=0x10001 -> out_valid exactly 33 cycles after acceptance, result=0x00010000, cout=1; in_ready=0 throughout; macro undefined -> 1 cycle, err=1, result=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after XOR A=0xF0F0F0F0, B=0xFF00FF00 -> result stays 0x0FF00FF0, in_valid ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 Assert Reset_n=0 at cycle 10 of MUL -> out_valid=0, result=0 immediately; after release, new ADD 2+2 returns 4 with no stale output.
